// File: rtl/hash_uart_tx.sv
// Buffers 128-bit result words in a small FIFO and serialises them MSB byte first
// over a valid/ready byte handshake. Define HASH_UART_TX_HEX_ASCII_EN for hex+CRLF output.
module hash_uart_tx #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [127:0]      i_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              o_busy,
    output logic [DROP_W-1:0] o_drop_cnt
);

    localparam int unsigned WORD_W = 128;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned IDX_W  = 6;
`ifdef HASH_UART_TX_HEX_ASCII_EN
    localparam int unsigned SHIFT  = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(33);
`else
    localparam int unsigned SHIFT  = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(15);
`endif

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic [DROP_W-1:0]   drop_cnt_q;
    logic                pop, push, drop;

`ifdef HASH_UART_TX_HEX_ASCII_EN
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Characters 0..31 come from the top nibble; 32 and 33 are the CR/LF terminator.
    function automatic logic [7:0] byte_of(input logic [WORD_W-1:0] s, input logic [IDX_W-1:0] idx);
        if (idx < IDX_W'(32))       return hex_char(s[WORD_W-1 -: 4]);
        else if (idx == IDX_W'(32)) return 8'h0D;
        else                        return 8'h0A;
    endfunction
`else
    function automatic logic [7:0] byte_of(input logic [WORD_W-1:0] s);
        return s[WORD_W-1 -: 8];
    endfunction
`endif

    // Serialiser: IDLE pops the head; SEND raises tx_valid one cycle later and shifts per transfer.
    always_comb begin
        pop        = 1'b0;
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                end else if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shift_d = mem[rd_ptr_q];
                            idx_d   = '0;
                        end else begin
                            state_d    = IDLE;
                            tx_valid_d = 1'b0;
                        end
                    end else begin
                        shift_d = shift_q << SHIFT;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef HASH_UART_TX_HEX_ASCII_EN
        tx_data_d = byte_of(shift_d, idx_d);
`else
        tx_data_d = byte_of(shift_d);
`endif
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        push    = i_valid && ((count_q != CNT_W'(DEPTH)) || pop);
        drop    = i_valid && (count_q == CNT_W'(DEPTH)) && !pop;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        busy_d  = (state_d == SEND) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + DROP_W'(1);
            end
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign o_busy     = busy_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule
